mem_port_arbiter: RTL and testbench

- Shares one single-port synchronous RAM between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage MIPS pipeline.
- Arbitrates between the two requesters and sequences the multi-cycle RAM access.
- Returns read data through registered per-requester ports.
- Generates stall_if / stall_mem, which the pipeline control ORs with the hazard-unit stall.

---
 rtl/mem_port_arbiter_if.sv | 38 +++
 rtl/mem_port_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the IF/MEM requester ports, the RAM port and the stall outputs
// that connect the memory-port arbiter to the pipeline and the RAM.
interface mem_port_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic [DATA_WIDTH-1:0] if_rdata;
  logic                  if_ready;
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ready;
  logic                  ram_en;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  stall_if;
  logic                  stall_mem;

  // Arbiter side.
  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata,
    output if_rdata, if_ready, mem_rdata, mem_ready,
    output ram_en, ram_we, ram_addr, ram_wdata, stall_if, stall_mem
  );

  // Pipeline / RAM environment side.
  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata,
    input  if_rdata, if_ready, mem_rdata, mem_ready,
    input  ram_en, ram_we, ram_addr, ram_wdata, stall_if, stall_mem
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch and the
// load/store stage. Round-robin on ties, fixed WAIT_CYCLES access length,
// registered read data and one-cycle ready pulses per requester.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_CYCLES = 2
) (
  input logic      clk,
  input logic      rst,
  mem_port_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic {OWN_IF = 1'b0, OWN_MEM = 1'b1} owner_t;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t                state_reg, state_next;
  owner_t                owner_reg, last_grant_reg, grant_owner;
  logic                  grant_valid;
  logic                  busy_last;
  logic [3:0]            cnt_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic                  we_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic [DATA_WIDTH-1:0] if_rdata_reg, mem_rdata_reg;
  logic                  if_ready_reg, mem_ready_reg;
  logic                  ram_en_next, ram_we_next;
  logic [ADDR_WIDTH-1:0] ram_addr_next;
  logic [DATA_WIDTH-1:0] ram_wdata_next;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next state, arbitration decision and RAM port drive.
  always_comb begin
    state_next     = state_reg;
    grant_valid    = 1'b0;
    grant_owner    = OWN_IF;
    busy_last      = 1'b0;
    ram_en_next    = 1'b0;
    ram_we_next    = 1'b0;
    ram_addr_next  = '0;
    ram_wdata_next = '0;
    case (state_reg)
      IDLE: begin
        if (bus.if_req || bus.mem_req) begin
          grant_valid = 1'b1;
          // A tie goes to whoever did not win last time.
          if (bus.if_req && bus.mem_req)
            grant_owner = (last_grant_reg == OWN_IF) ? OWN_MEM : OWN_IF;
          else
            grant_owner = bus.mem_req ? OWN_MEM : OWN_IF;
          state_next = BUSY;
        end
      end
      BUSY: begin
        ram_en_next    = 1'b1;
        ram_we_next    = we_reg;
        ram_addr_next  = addr_reg;
        ram_wdata_next = wdata_reg;
        if (cnt_reg == 4'd0) begin
          busy_last  = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request latch, access counter, fairness memory and per-requester results.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_reg      <= OWN_IF;
      last_grant_reg <= OWN_IF;
      cnt_reg        <= 4'd0;
      addr_reg       <= '0;
      we_reg         <= 1'b0;
      wdata_reg      <= '0;
      if_rdata_reg   <= '0;
      mem_rdata_reg  <= '0;
      if_ready_reg   <= 1'b0;
      mem_ready_reg  <= 1'b0;
    end else begin
      if_ready_reg  <= 1'b0;
      mem_ready_reg <= 1'b0;
      if (grant_valid) begin
        owner_reg      <= grant_owner;
        last_grant_reg <= grant_owner;
        cnt_reg        <= CNT_LOAD;
        if (grant_owner == OWN_MEM) begin
          addr_reg  <= bus.mem_addr;
          we_reg    <= bus.mem_we;
          wdata_reg <= bus.mem_wdata;
        end else begin
          // Fetches are always reads.
          addr_reg  <= bus.if_addr;
          we_reg    <= 1'b0;
          wdata_reg <= '0;
        end
      end else if (state_reg == BUSY && cnt_reg != 4'd0) begin
        cnt_reg <= cnt_reg - 4'd1;
      end
      if (busy_last) begin
        if (owner_reg == OWN_IF) begin
          if_ready_reg <= 1'b1;
          if_rdata_reg <= bus.ram_rdata;
        end else begin
          mem_ready_reg <= 1'b1;
          if (!we_reg) mem_rdata_reg <= bus.ram_rdata;
        end
      end
    end
  end

  assign bus.if_rdata  = if_rdata_reg;
  assign bus.if_ready  = if_ready_reg;
  assign bus.mem_rdata = mem_rdata_reg;
  assign bus.mem_ready = mem_ready_reg;
  assign bus.ram_en    = ram_en_next;
  assign bus.ram_we    = ram_we_next;
  assign bus.ram_addr  = ram_addr_next;
  assign bus.ram_wdata = ram_wdata_next;
  // Stalls follow the registered ready so they drop in the completion cycle.
  assign bus.stall_if  = bus.if_req & ~if_ready_reg;
  assign bus.stall_mem = bus.mem_req & ~mem_ready_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a transaction-level reference model
// compared every cycle, plus hand-computed expectations per scenario.
module tb_mem_port_arbiter;

  localparam int W = 2;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  mem_port_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .WAIT_CYCLES(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM content seen by the arbiter: one fixed instruction, otherwise a hash of the address.
  function automatic logic [31:0] ram_func(input logic [31:0] a);
    if (a == 32'h00400000) return 32'h2402000A;
    return a ^ 32'hA5A5A5A5;
  endfunction

  assign bus.ram_rdata = ram_func(bus.ram_addr);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a transaction granted in cycle g occupies the RAM in
  // cycles g+1..g+W and reports ready in cycle g+W+1.
  int          t = 0;
  bit          valid = 0;
  bit          m_active = 0;
  int          m_g = 0;
  bit          m_owner = 0;        // 0 = IF, 1 = MEM
  bit          m_last = 0;
  bit          m_we = 0;
  logic [31:0] m_addr = '0, m_wd = '0;
  logic [31:0] m_if_rd = '0, m_mem_rd = '0;
  int          grant_log[$];

  initial begin
    int k;
    bit en, ifr, memr;
    forever begin
      @(negedge clk);
      k    = t - m_g;
      en   = m_active && k >= 1 && k <= W;
      ifr  = m_active && k == W + 1 && !m_owner;
      memr = m_active && k == W + 1 && m_owner;
      if (valid) begin
        chk("m_ram_en", bus.ram_en, en);
        chk("m_ram_we", bus.ram_we, en && m_we);
        chk("m_ram_addr", bus.ram_addr, en ? m_addr : 32'h0);
        if (!en || m_owner) chk("m_ram_wdata", bus.ram_wdata, en ? m_wd : 32'h0);
        chk("m_if_ready", bus.if_ready, ifr);
        chk("m_mem_ready", bus.mem_ready, memr);
        chk("m_if_rdata", bus.if_rdata, m_if_rd);
        chk("m_mem_rdata", bus.mem_rdata, m_mem_rd);
        chk("m_stall_if", bus.stall_if, bus.if_req && !ifr);
        chk("m_stall_mem", bus.stall_mem, bus.mem_req && !memr);
      end
      if (rst) begin
        m_active = 0; m_last = 0; m_if_rd = '0; m_mem_rd = '0; valid = 1;
      end else if (valid) begin
        if (m_active) begin
          if (k == W && !m_we) begin
            if (m_owner) m_mem_rd = ram_func(m_addr);
            else         m_if_rd  = ram_func(m_addr);
          end
          if (k == W + 1) m_active = 0;
        end else if (bus.if_req || bus.mem_req) begin
          m_owner  = (bus.if_req && bus.mem_req) ? !m_last : bus.mem_req;
          m_last   = m_owner;
          m_addr   = m_owner ? bus.mem_addr : bus.if_addr;
          m_we     = m_owner && bus.mem_we;
          m_wd     = m_owner ? bus.mem_wdata : 32'h0;
          m_g      = t;
          m_active = 1;
          grant_log.push_back(int'(m_owner));
        end
      end
      t++;
    end
  end

  // Directed scenarios; cycle c = 0 is the cycle in which the request is first seen.
  initial begin
    rst = 1'b1;
    bus.if_req = 1'b1; bus.mem_req = 1'b1;
    bus.if_addr = 32'h00400000; bus.mem_addr = 32'h10010004;
    bus.mem_we = 1'b0; bus.mem_wdata = 32'h0;
    @(posedge clk); @(negedge clk);
    chk("rst_ram_en", bus.ram_en, 0);
    chk("rst_if_ready", bus.if_ready, 0);
    chk("rst_mem_ready", bus.mem_ready, 0);
    chk("rst_if_rdata", bus.if_rdata, 0);
    chk("rst_mem_rdata", bus.mem_rdata, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Tie fairness: MEM, IF, MEM.
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk($sformatf("tie_mem_ready_c%0d", c), bus.mem_ready, (c == 3 || c == 11));
      chk($sformatf("tie_if_ready_c%0d", c), bus.if_ready, (c == 7));
      chk($sformatf("tie_stall_mem_c%0d", c), bus.stall_mem, !(c == 3 || c == 11));
      if (c == 1) chk("tie_first_addr", bus.ram_addr, 32'h10010004);
      if (c == 5) chk("tie_second_addr", bus.ram_addr, 32'h00400000);
      if (c == 3) chk("tie_mem_rdata", bus.mem_rdata, 32'hB5A4A5A1);
      if (c == 7) chk("tie_if_rdata", bus.if_rdata, 32'h2402000A);
    end
    @(posedge clk); #1 bus.if_req = 1'b0; bus.mem_req = 1'b0;
    chk("model_grant_count", grant_log.size(), 3);
    if (grant_log.size() >= 3) begin
      chk("model_grant0", grant_log[0], 1);
      chk("model_grant1", grant_log[1], 0);
      chk("model_grant2", grant_log[2], 1);
    end

    // IF read.
    @(posedge clk); #1 bus.if_req = 1'b1; bus.if_addr = 32'h00400000;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("ifrd_ram_en_c%0d", c), bus.ram_en, (c == 1 || c == 2));
      if (c == 1 || c == 2) begin
        chk("ifrd_ram_addr", bus.ram_addr, 32'h00400000);
        chk("ifrd_ram_we", bus.ram_we, 0);
      end
      chk($sformatf("ifrd_if_ready_c%0d", c), bus.if_ready, (c == 3));
      chk($sformatf("ifrd_stall_if_c%0d", c), bus.stall_if, (c < 3));
      if (c == 3) begin
        chk("ifrd_if_rdata", bus.if_rdata, 32'h2402000A);
        @(posedge clk); #1 bus.if_req = 1'b0;
      end
    end

    // Store leaves mem_rdata untouched.
    @(posedge clk); #1
    bus.mem_req = 1'b1; bus.mem_we = 1'b1;
    bus.mem_addr = 32'h10010000; bus.mem_wdata = 32'hDEADBEEF;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("st_ram_we_c%0d", c), bus.ram_we, (c == 1 || c == 2));
      if (c == 1 || c == 2) begin
        chk("st_ram_addr", bus.ram_addr, 32'h10010000);
        chk("st_ram_wdata", bus.ram_wdata, 32'hDEADBEEF);
      end
      chk($sformatf("st_mem_ready_c%0d", c), bus.mem_ready, (c == 3));
      chk($sformatf("st_mem_rdata_c%0d", c), bus.mem_rdata, 32'hB5A4A5A1);
    end
    @(posedge clk); #1 bus.mem_req = 1'b0; bus.mem_we = 1'b0;

    // Flush: request withdrawn after the grant.
    @(posedge clk); #1 bus.if_req = 1'b1; bus.if_addr = 32'h00400010;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("fl_ram_en_c%0d", c), bus.ram_en, (c == 1 || c == 2));
      chk($sformatf("fl_if_ready_c%0d", c), bus.if_ready, (c == 3));
      if (c == 3) chk("fl_if_rdata", bus.if_rdata, 32'hA5E5A5B5);
      if (c == 0) begin
        @(posedge clk); #1 bus.if_req = 1'b0;
      end
    end

    // Reset during an IF access, then both requesters: MEM first.
    @(posedge clk); #1 bus.if_req = 1'b1; bus.if_addr = 32'h00400000;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 1) chk("rb_busy_before_rst", bus.ram_en, 1);
      if (c == 2) begin
        chk("rb_ram_en_after_rst", bus.ram_en, 0);
        chk("rb_if_rdata_cleared", bus.if_rdata, 0);
        chk("rb_mem_rdata_cleared", bus.mem_rdata, 0);
      end
      if (c >= 2) chk($sformatf("rb_no_if_ready_c%0d", c), bus.if_ready, 0);
      if (c == 3) chk("rb_mem_first_addr", bus.ram_addr, 32'h10010008);
      if (c == 5) chk("rb_mem_ready", bus.mem_ready, 1);
      if (c == 0) begin
        @(posedge clk); #1 rst = 1'b1;
      end else if (c == 1) begin
        @(posedge clk); #1 rst = 1'b0; bus.mem_req = 1'b1; bus.mem_addr = 32'h10010008;
      end
    end
    @(posedge clk); #1 bus.if_req = 1'b0; bus.mem_req = 1'b0;

    // Reset during a MEM access must restore IF as last grant, so MEM wins the tie.
    @(posedge clk); #1 bus.mem_req = 1'b1; bus.mem_addr = 32'h1001000C;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 3) chk("rm_mem_first_addr", bus.ram_addr, 32'h1001000C);
      if (c == 5) chk("rm_mem_ready", bus.mem_ready, 1);
      if (c == 0) begin
        @(posedge clk); #1 rst = 1'b1;
      end else if (c == 1) begin
        @(posedge clk); #1 rst = 1'b0; bus.if_req = 1'b1;
      end
    end
    @(posedge clk); #1 bus.if_req = 1'b0; bus.mem_req = 1'b0;

    repeat (6) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
